sync_up_counter: RTL and testbench

- Synchronous modulo-N up counter; the up-counting counterpart of the team's ripple down counter.
- All bits update on the single clock edge; no ripple clocks.
- Adds enable, synchronous clear, parallel load, terminal-count pulse and sticky wrap flag.
- Serves as a timebase/event counter for downstream blocks and for verifying down-counter sequences end to end.

---
 rtl/sync_up_counter.sv | 102 ++++++++++
 tb/tb_sync_up_counter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sync_up_counter.sv
// rtl/sync_up_counter.sv - synchronous modulo-MODULUS up counter with enable, clear, load, tc and sticky wrap
// Optional Gray-coded output zg is enabled by defining SYNC_UP_COUNTER_GRAY_OUT_EN.
module sync_up_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] z,
  output logic             tc,
  output logic             wrap,
  input  logic             wrap_ack
`ifdef SYNC_UP_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] zg
`endif
);

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("sync_up_counter: WIDTH must be in 2..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("sync_up_counter: MODULUS must be in 2..2**WIDTH");
    end
`ifdef SYNC_UP_COUNTER_GRAY_OUT_EN
    if ((MODULUS & (MODULUS - 1)) != 0) begin : g_bad_gray
      $error("sync_up_counter: Gray output needs a power-of-two MODULUS");
    end
`endif
  endgenerate

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] z_next;
  logic             wrap_next;
  logic [WIDTH:0]   inc;
  logic             at_last;

  // The increment keeps its carry so MODULUS == 2**WIDTH compares without truncation.
  assign inc     = {1'b0, z} + {{WIDTH{1'b0}}, 1'b1};
  assign at_last = (inc == MOD_EXT);

  always_comb begin
    z_next    = z;
    wrap_next = wrap;
    state_d   = state_q;
    tc        = at_last & en & ~clr & ~ld;

    if (clr) begin
      z_next = '0;
    end else if (ld) begin
      z_next = (d > LAST) ? LAST : d;
    end else if (en) begin
      z_next = at_last ? '0 : inc[WIDTH-1:0];
    end

    if (tc) begin
      wrap_next = 1'b1;
    end else if (wrap_ack) begin
      wrap_next = 1'b0;
    end

    if (state_q == IDLE && (en || ld)) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      z       <= '0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      z       <= z_next;
      wrap    <= wrap_next;
    end
  end

`ifdef SYNC_UP_COUNTER_GRAY_OUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zg <= '0;
    end else begin
      zg <= z_next ^ (z_next >> 1);
    end
  end
`endif

  // The counter can only sit idle at zero; anything else means a missed transition.
  a_idle_zero : assert property (@(posedge clk) disable iff (!rst) (state_q == IDLE) |-> (z == '0));

endmodule

// File: tb/tb_sync_up_counter.sv
// tb/tb_sync_up_counter.sv - scoreboard bench for sync_up_counter with a modulus-16 and a small-modulus instance
module tb_sync_up_counter;

  localparam int M0 = 16;
`ifdef SYNC_UP_COUNTER_GRAY_OUT_EN
  localparam int M1 = 8;
`else
  localparam int M1 = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, clr = 1'b0, ld = 1'b0, wrap_ack = 1'b0;
  logic [3:0] d = 4'd0;
  logic [3:0] z0, z1;
  logic       tc0, tc1, wrap0, wrap1;
`ifdef SYNC_UP_COUNTER_GRAY_OUT_EN
  logic [3:0] zg0, zg1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sync_up_counter #(.WIDTH(4), .MODULUS(M0)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .d(d),
    .z(z0), .tc(tc0), .wrap(wrap0), .wrap_ack(wrap_ack)
`ifdef SYNC_UP_COUNTER_GRAY_OUT_EN
    , .zg(zg0)
`endif
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(M1)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .d(d),
    .z(z1), .tc(tc1), .wrap(wrap1), .wrap_ack(wrap_ack)
`ifdef SYNC_UP_COUNTER_GRAY_OUT_EN
    , .zg(zg1)
`endif
  );

  typedef struct {
    int z0; int w0; int tc0;
    int z1; int w1; int tc1;
  } exp_t;

  exp_t q[$];

  int m0_z = 0, m0_w = 0, m1_z = 0, m1_w = 0;

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int model_tc(input int z, input int m, input logic e, input logic c, input logic l);
    return (z == m - 1 && e && !c && !l) ? 1 : 0;
  endfunction

  function automatic int model_z(input int z, input int m, input logic e, input logic c, input logic l, input int dv);
    if (c) return 0;
    if (l) return (dv > m - 1) ? m - 1 : dv;
    if (e) return (z + 1) % m;
    return z;
  endfunction

  function automatic int model_w(input int w, input int tcv, input logic a);
    if (tcv != 0) return 1;
    if (a) return 0;
    return w;
  endfunction

  // Called at posedge+1: drive inputs, record what the DUT must show before the next edge, advance model.
  task automatic step(input logic e, input logic c, input logic l, input logic [3:0] dv, input logic a);
    exp_t x;
    int t0, t1;
    en = e; clr = c; ld = l; d = dv; wrap_ack = a;
    t0 = model_tc(m0_z, M0, e, c, l);
    t1 = model_tc(m1_z, M1, e, c, l);
    x.z0 = m0_z; x.w0 = m0_w; x.tc0 = t0;
    x.z1 = m1_z; x.w1 = m1_w; x.tc1 = t1;
    q.push_back(x);
    @(posedge clk);
    #1;
    m0_z = model_z(m0_z, M0, e, c, l, int'(dv));
    m1_z = model_z(m1_z, M1, e, c, l, int'(dv));
    m0_w = model_w(m0_w, t0, a);
    m1_w = model_w(m1_w, t1, a);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("z0", int'(z0), x.z0);
      chk("tc0", int'(tc0), x.tc0);
      chk("wrap0", int'(wrap0), x.w0);
      chk("z1", int'(z1), x.z1);
      chk("tc1", int'(tc1), x.tc1);
      chk("wrap1", int'(wrap1), x.w1);
`ifdef SYNC_UP_COUNTER_GRAY_OUT_EN
      chk("zg0", int'(zg0), x.z0 ^ (x.z0 >> 1));
      chk("zg1", int'(zg1), x.z1 ^ (x.z1 >> 1));
`endif
    end
  end

  initial begin
    #1;
    chk("reset_z0", int'(z0), 0);
    chk("reset_wrap0", int'(wrap0), 0);
    chk("reset_tc0", int'(tc0), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset mid-clock from z=9, then count 1,2,3
    step(0, 0, 1, 4'd9, 0);
    step(0, 0, 0, 4'd0, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_z0", int'(z0), 0);
    chk("async_reset_wrap0", int'(wrap0), 0);
    chk("async_reset_z1", int'(z1), 0);
    m0_z = 0; m0_w = 0; m1_z = 0; m1_w = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 4'd0, 0);

    // Free run from zero through a full wrap
    step(0, 1, 0, 4'd0, 1);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 4'd0, 0);
    step(0, 0, 0, 4'd0, 0);

    // Priority clr > ld > en, then load clamp
    step(0, 0, 1, 4'd5, 1);
    step(1, 1, 1, 4'd7, 0);
    step(0, 0, 1, 4'd7, 0);
    step(0, 0, 1, 4'd12, 0);
    step(0, 0, 0, 4'd0, 0);

    // Wrap and wrap_ack on the same edge: set wins; then ack alone clears
    step(0, 0, 1, 4'd9, 1);
    step(1, 0, 0, 4'd0, 1);
    step(0, 0, 0, 4'd0, 1);
    step(0, 0, 0, 4'd0, 0);

    // Enable gating from 3, and tc held low at z=15 with en=0
    step(0, 0, 1, 4'd3, 0);
    for (int i = 0; i < 4; i++) step(logic'(i % 2 == 0), 0, 0, 4'd0, 0);
    step(0, 0, 1, 4'd15, 0);
    step(0, 0, 0, 4'd0, 0);
    step(1, 0, 0, 4'd0, 0);

    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 15)),
           logic'($urandom_range(0, 4) == 0));
    end
    step(0, 0, 0, 4'd0, 0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
